bf16_prod_node_seq: RTL

BF16_PROD_NODE_SEQ -- requirements
Module: bf16_prod_node_seq

---
 rtl/prod_node_pkg.sv | 25 ++
 rtl/bf16_prod_node_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/prod_node_pkg.sv
// Shared types and BF16 field layout for the serial BF16 product node.
package prod_node_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int BF16_SIGN   = 15;
  localparam int BF16_EXP_HI = 14;
  localparam int BF16_EXP_LO = 7;
  localparam int BF16_MAN_HI = 6;
  localparam int BF16_MAN_LO = 0;

  localparam int DEF_MUL_LAT = 3;

  // A zero exponent field covers both signed zeros and subnormals.
  function automatic logic bf16_exp_zero(input logic [15:0] v);
    return v[BF16_EXP_HI:BF16_EXP_LO] == '0;
  endfunction

endpackage

// File: rtl/bf16_prod_node_seq.sv
// Serial BF16 product of a node's children using one external fixed-latency multiplier.
// Optional PROD_NODE_ZERO_SKIP_EN: stop issuing multiplies once the running product is zero.
module bf16_prod_node_seq
  import prod_node_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_stb,
  input  logic             in_last,
  output logic             in_ack,
  output logic [31:0]      mul_operands,
  output logic             mul_stb,
  input  logic [15:0]      mul_z,
  input  logic             mul_z_stb,
  output logic [15:0]      out_z,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             lat_err
);

  localparam int LW = $clog2(MUL_LAT) + 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MUL_LAT - 1);

  state_t           state;
  logic [15:0]      acc;
  logic [15:0]      x;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [LW-1:0]    lat_cnt;
  logic             seen_stb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign in_ack       = (state == IDLE) || (state == ACC);
  assign mul_operands = {acc, x};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      x        <= '0;
      last     <= 1'b0;
      cnt      <= '0;
      lat_cnt  <= '0;
      seen_stb <= 1'b0;
      mul_stb  <= 1'b0;
      out_z    <= '0;
      out_cnt  <= '0;
      out_stb  <= 1'b0;
      lat_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_stb) begin
            acc <= in_data;
            cnt <= CNT_W'(1);
            if (in_last) begin
              out_z   <= in_data;
              out_cnt <= CNT_W'(1);
              out_stb <= 1'b1;
              state   <= OUT;
            end else begin
              state <= ACC;
            end
          end
        end

        ACC: begin
          if (in_stb) begin
            cnt <= sat_inc(cnt);
`ifdef PROD_NODE_ZERO_SKIP_EN
            if (bf16_exp_zero(acc)) begin
              // Product is already zero: absorb the child without a multiply.
              if (in_last) begin
                out_z   <= acc;
                out_cnt <= sat_inc(cnt);
                out_stb <= 1'b1;
                state   <= OUT;
              end
            end else begin
              x       <= in_data;
              last    <= in_last;
              mul_stb <= 1'b1;
              state   <= ISSUE;
            end
`else
            x       <= in_data;
            last    <= in_last;
            mul_stb <= 1'b1;
            state   <= ISSUE;
`endif
          end
        end

        ISSUE: begin
          mul_stb  <= 1'b0;
          lat_cnt  <= '0;
          seen_stb <= 1'b0;
          state    <= WAIT;
        end

        WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (mul_z_stb) seen_stb <= 1'b1;
          // Capture is time-based; a missing strobe is only flagged, never waited for.
          if (lat_cnt == LAT_LAST) begin
            acc <= mul_z;
            if (!(seen_stb || mul_z_stb)) lat_err <= 1'b1;
            if (last) begin
              out_z   <= mul_z;
              out_cnt <= cnt;
              out_stb <= 1'b1;
              state   <= OUT;
            end else begin
              state <= ACC;
            end
          end
        end

        OUT: begin
          if (out_ack) begin
            out_stb <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
